// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared declarations for the PS/2 host-side blocks: the transmitter state
// encoding, common command bytes, default timing constants and the parity
// helper.
// ---------------------------------------------------------------------------
package ps2_pkg;

  // Transmitter phases, in the order a transfer walks through them
  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    SHIFT,
    WAIT_IDLE
  } ps2_tx_state_e;

  // Frequently used host-to-keyboard commands and the keyboard acknowledge
  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_ACK          = 8'hFA;

  // Default timing, in system clock cycles
  localparam int PS2_INHIBIT_CYCLES_DEF = 13000;
  localparam int PS2_FILTER_CYCLES_DEF  = 1000;
  localparam int PS2_TIMEOUT_CYCLES_DEF = 50000;

  // PS/2 frames carry odd parity: the parity bit makes the total count of ones odd
  function automatic logic ps2OddParity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// ---------------------------------------------------------------------------
// ps2_line_filter
// Synchronises one raw PS/2 line into the clk_i domain and only lets the
// filtered level follow once the synchronised input has held its new value
// for FILTER_CYCLES consecutive cycles. One-cycle fall/rise strobes mark the
// cycle in which the filtered level changes. One instance per line; an
// instance may be shared with the scan-code receiver.
//
// Ports
//   clk_i    system clock
//   rst_ni   asynchronous active-low reset (filtered level resets high = idle bus)
//   line_i   raw line read back from the pad
//   level_o  filtered line level
//   fall_o   one-cycle strobe, filtered level went 1 -> 0
//   rise_o   one-cycle strobe, filtered level went 0 -> 1
// ---------------------------------------------------------------------------
module ps2_line_filter
  import ps2_pkg::*;
#(
  parameter int FILTER_CYCLES = PS2_FILTER_CYCLES_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic line_i,
  output logic level_o,
  output logic fall_o,
  output logic rise_o
);

  localparam int CW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam logic [CW-1:0] STABLE_LAST = CW'(FILTER_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          level_q, level_d;
  logic [CW-1:0] stableCnt_q, stableCnt_d;
  logic          fall_q, fall_d;
  logic          rise_q, rise_d;

  // Stability counter: counts consecutive cycles in which the synchronised
  // input disagrees with the filtered level. Any agreement clears it, so a
  // glitch shorter than FILTER_CYCLES never reaches the output. The counter
  // stops at STABLE_LAST because it is cleared as soon as the level updates.
  always_comb begin
    level_d     = level_q;
    stableCnt_d = '0;
    fall_d      = 1'b0;
    rise_d      = 1'b0;
    if (sync_q[1] != level_q) begin
      if (stableCnt_q == STABLE_LAST) begin
        level_d = sync_q[1];
        fall_d  = level_q;
        rise_d  = ~level_q;
      end else begin
        stableCnt_d = stableCnt_q + 1'b1;
      end
    end
  end

  // Two-flop synchroniser for the asynchronous pad input, then the filter
  // state. Everything resets to the idle (released, high) bus level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q      <= 2'b11;
      level_q     <= 1'b1;
      stableCnt_q <= '0;
      fall_q      <= 1'b0;
      rise_q      <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], line_i};
      level_q     <= level_d;
      stableCnt_q <= stableCnt_d;
      fall_q      <= fall_d;
      rise_q      <= rise_d;
    end
  end

  assign level_o = level_q;
  assign fall_o  = fall_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/ps2_host_tx.sv
// ---------------------------------------------------------------------------
// ps2_host_tx
// Host-to-device PS/2 transmitter. Sends one command byte to the keyboard:
// inhibits the bus, issues request-to-send, shifts out 8 data bits (LSB
// first), odd parity and stop on falling edges of the device clock, then
// samples the device ACK. Both lines are driven open-drain through the
// *_drive_low outputs.
//
// Configuration macro: PS2_TX_TIMEOUT_EN
//   defined   - watchdog: if the device clock stalls for TIMEOUT_CYCLES in
//               RTS/SHIFT, or the bus does not return idle in WAIT_IDLE, the
//               transfer ends with tx_done_o and tx_err_o set.
//   undefined - no watchdog; the block waits indefinitely for the device.
//
// Ports
//   clk_i                 system clock
//   rst_ni                asynchronous active-low reset
//   tx_data_i[7:0]        command byte, latched on accept
//   tx_valid_i            request to send tx_data_i
//   tx_ready_o            high only in IDLE (and low while in reset)
//   kbd_clk_i             raw PS/2 clock line read back from the pad
//   kbd_data_i            raw PS/2 data line read back from the pad
//   kbd_clk_drive_low_o   1 = pull kbd_clk low, 0 = release
//   kbd_data_drive_low_o  1 = pull kbd_data low, 0 = release
//   tx_busy_o             high from accept until the done pulse
//   tx_done_o             one-cycle pulse at the end of every transfer
//   tx_err_o              valid with tx_done_o: no ACK or timeout
// ---------------------------------------------------------------------------
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = PS2_INHIBIT_CYCLES_DEF,
  parameter int FILTER_CYCLES  = PS2_FILTER_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES_DEF
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  input  logic       kbd_clk_i,
  input  logic       kbd_data_i,
  output logic       kbd_clk_drive_low_o,
  output logic       kbd_data_drive_low_o,
  output logic       tx_busy_o,
  output logic       tx_done_o,
  output logic       tx_err_o
);

  // One cycle counter serves both the inhibit phase and the watchdog
  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
`ifdef PS2_TX_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

  ps2_tx_state_e    state_q, state_d;
  logic [CNT_W-1:0] cycleCnt_q, cycleCnt_d;
  logic [3:0]       bitCnt_q, bitCnt_d;
  logic [9:0]       frame_q, frame_d;
  logic             dataLow_q, dataLow_d;
  logic             ackErr_q, ackErr_d;
  logic             active_q;

  logic clkLevel, clkFall, clkRise;
  logic dataLevel, dataFall, dataRise;
  logic accept, txReady, done, timeoutErr;
  logic clkDriveLow, dataDriveLow;
  logic unusedStrobes;

  ps2_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_clk_filter (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .line_i  (kbd_clk_i),
    .level_o (clkLevel),
    .fall_o  (clkFall),
    .rise_o  (clkRise)
  );

  ps2_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_data_filter (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .line_i  (kbd_data_i),
    .level_o (dataLevel),
    .fall_o  (dataFall),
    .rise_o  (dataRise)
  );

  // Only the clock falling edge advances the transfer; the remaining
  // strobes exist for a receiver sharing these filter instances.
  assign unusedStrobes = clkRise ^ dataFall ^ dataRise;

  // tx_ready must stay low while reset is asserted even though the state
  // register already sits in IDLE, hence the separate out-of-reset flag.
  assign txReady = active_q & (state_q == IDLE);
  assign accept  = tx_valid_i & txReady;

  // Next-state and pad-drive logic. frame_q holds {stop, parity, data} and is
  // shifted right on each device clock fall, so bit 0 is always the next bit
  // to present. RTS waits for the released clock to read back high so the
  // fall caused by our own inhibit can never be mistaken for a device edge.
  always_comb begin
    state_d      = state_q;
    cycleCnt_d   = (cycleCnt_q == {CNT_W{1'b1}}) ? cycleCnt_q : cycleCnt_q + 1'b1;
    bitCnt_d     = bitCnt_q;
    frame_d      = frame_q;
    dataLow_d    = dataLow_q;
    ackErr_d     = ackErr_q;
    done         = 1'b0;
    timeoutErr   = 1'b0;
    clkDriveLow  = 1'b0;
    dataDriveLow = 1'b0;

    case (state_q)
      IDLE: begin
        cycleCnt_d = '0;
        bitCnt_d   = '0;
        dataLow_d  = 1'b0;
        if (accept) begin
          frame_d  = {1'b1, ps2OddParity(tx_data_i), tx_data_i};
          ackErr_d = 1'b0;
          state_d  = INHIBIT;
        end
      end

      INHIBIT: begin
        clkDriveLow  = 1'b1;
        dataDriveLow = (cycleCnt_q == INHIBIT_LAST);
        if (cycleCnt_q == INHIBIT_LAST) begin
          cycleCnt_d = '0;
          dataLow_d  = 1'b1;
          state_d    = RTS;
        end
      end

      RTS: begin
        dataDriveLow = 1'b1;
        bitCnt_d     = '0;
        if (clkLevel) begin
          cycleCnt_d = '0;
          state_d    = SHIFT;
        end
      end

      SHIFT: begin
        dataDriveLow = dataLow_q;
        if (clkFall) begin
          cycleCnt_d = '0;
          if (bitCnt_q != 4'd11) begin
            bitCnt_d = bitCnt_q + 4'd1;
          end
          if (bitCnt_q <= 4'd9) begin
            dataLow_d = ~frame_q[0];
            frame_d   = {1'b1, frame_q[9:1]};
          end else begin
            ackErr_d  = dataLevel;
            dataLow_d = 1'b0;
            state_d   = WAIT_IDLE;
          end
        end
      end

      WAIT_IDLE: begin
        if (clkLevel && dataLevel) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

`ifdef PS2_TX_TIMEOUT_EN
    // Watchdog overrides the normal flow: release the bus and finish with an error
    if (cycleCnt_q == TIMEOUT_LAST &&
        ((state_q == RTS) ||
         (state_q == SHIFT && !clkFall) ||
         (state_q == WAIT_IDLE && !(clkLevel && dataLevel)))) begin
      done         = 1'b1;
      timeoutErr   = 1'b1;
      clkDriveLow  = 1'b0;
      dataDriveLow = 1'b0;
      dataLow_d    = 1'b0;
      state_d      = IDLE;
    end
`endif
  end

  // State and datapath registers; reset returns to IDLE and thereby releases
  // both lines immediately through the decode above.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cycleCnt_q <= '0;
      bitCnt_q   <= '0;
      frame_q    <= '0;
      dataLow_q  <= 1'b0;
      ackErr_q   <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cycleCnt_q <= cycleCnt_d;
      bitCnt_q   <= bitCnt_d;
      frame_q    <= frame_d;
      dataLow_q  <= dataLow_d;
      ackErr_q   <= ackErr_d;
      active_q   <= 1'b1;
    end
  end

  assign tx_ready_o           = txReady;
  assign tx_busy_o            = (state_q != IDLE);
  assign tx_done_o            = done;
  assign tx_err_o             = timeoutErr | (done & ackErr_q);
  assign kbd_clk_drive_low_o  = clkDriveLow;
  assign kbd_data_drive_low_o = dataDriveLow;

endmodule

// File: tb/tb_ps2_host_tx.sv
// ---------------------------------------------------------------------------
// tb_ps2_host_tx
// Self-checking bench for ps2_host_tx with a keyboard-side bus model that
// clocks the frame, reads the data line and optionally acknowledges.
// ---------------------------------------------------------------------------
module tb_ps2_host_tx;

  localparam int INH  = 20;
  localparam int FIL  = 4;
  localparam int TO   = 200;
  localparam int HALF = 40;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] txData = 8'h00;
  logic       txValid = 1'b0;
  logic       txReady, clkDrv, dataDrv, txBusy, txDone, txErr;
  logic       devClkLow = 1'b0;
  logic       devDataLow = 1'b0;
  logic       kbdClk, kbdData;

  // Open-drain bus: a line is low if either side pulls it down
  assign kbdClk  = ~(clkDrv | devClkLow);
  assign kbdData = ~(dataDrv | devDataLow);

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .FILTER_CYCLES  (FIL),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_i                (clk),
    .rst_ni               (rst_n),
    .tx_data_i            (txData),
    .tx_valid_i           (txValid),
    .tx_ready_o           (txReady),
    .kbd_clk_i            (kbdClk),
    .kbd_data_i           (kbdData),
    .kbd_clk_drive_low_o  (clkDrv),
    .kbd_data_drive_low_o (dataDrv),
    .tx_busy_o            (txBusy),
    .tx_done_o            (txDone),
    .tx_err_o             (txErr)
  );

  int checkCount = 0;
  int passCount  = 0;

  typedef struct {
    logic [7:0] data;
    bit         ack;
    bit         glitch;
    bit         poke;
    logic       expParity;
    bit         expErr;
  } vec_t;

  vec_t vecs[7];

  // Reference frame as it should appear on the data line: start 0, data LSB
  // first, odd parity, stop 1. Bit k is what the device reads on clock k.
  function automatic logic [10:0] modelFrame(input logic [7:0] b);
    logic par;
    par = (($countones(b) % 2) == 0);
    return {1'b1, par, b, 1'b0};
  endfunction

  // Compare one value and keep the running tallies
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Present a byte for one cycle and scramble tx_data right after accept
  task automatic applyStimulus(input logic [7:0] b);
    @(negedge clk);
    txData  = b;
    txValid = 1'b1;
    checkOutput("ready_before_accept", {31'd0, txReady}, 32'd1);
    @(negedge clk);
    txValid = 1'b0;
    txData  = ~b;
  endtask

  // Measure the inhibit phase, then check the request-to-send state
  task automatic checkInhibit();
    int n = 0;
    int dataIdx = 0;
    int guard = 0;
    while (!clkDrv && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    while (clkDrv && n < 200) begin
      n++;
      if (dataDrv && dataIdx == 0) dataIdx = n;
      @(negedge clk);
    end
    checkOutput("inhibit_cycles", n, INH);
    checkOutput("data_low_cycle", dataIdx, INH);
    checkOutput("rts_data_low", {31'd0, dataDrv}, 32'd1);
  endtask

  // Keyboard side: clocks up to 11 bits, reads each bit at the end of the
  // clock-low half, optionally acknowledges, glitches, pokes tx_valid,
  // resets the DUT at bit resetAt or stalls after bit stallAfter.
  task automatic deviceFrame(input bit ack, input bit glitch, input bit poke,
                             input int resetAt, input int stallAfter,
                             output logic [10:0] bits);
    bits    = '1;
    bits[0] = kbdData;
    for (int k = 1; k <= 11; k++) begin
      if (k == 11 && ack) devDataLow = 1'b1;
      if (glitch && k == 5) begin
        repeat (20) @(negedge clk);
        devClkLow = 1'b1;
        repeat (2) @(negedge clk);
        devClkLow = 1'b0;
        repeat (HALF - 22) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      devClkLow = 1'b1;
      if (resetAt == k) begin
        repeat (20) @(negedge clk);
        checkOutput("drive_before_reset", {31'd0, dataDrv}, 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("reset_drives_released", {30'd0, clkDrv, dataDrv}, 32'd0);
        checkOutput("reset_ready_low", {31'd0, txReady}, 32'd0);
        devClkLow  = 1'b0;
        devDataLow = 1'b0;
        return;
      end
      if (poke && k == 3) begin
        repeat (10) @(negedge clk);
        txData  = 8'h12;
        txValid = 1'b1;
        @(negedge clk);
        txValid = 1'b0;
        repeat (HALF - 11) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      if (k <= 10) bits[k] = kbdData;
      devClkLow = 1'b0;
      if (stallAfter == k) return;
    end
    if (ack) begin
      repeat (HALF) @(negedge clk);
      devDataLow = 1'b0;
    end
  endtask

  // Wait (bounded) for the done pulse; lat counts the cycles waited
  task automatic waitDone(output bit seen, output logic err, output logic rdy,
                          output logic busy, output int lat);
    seen = 1'b0;
    err  = 1'b0;
    rdy  = 1'b0;
    busy = 1'b0;
    lat  = 0;
    for (int i = 0; i < 400; i++) begin
      if (txDone) begin
        seen = 1'b1;
        err  = txErr;
        rdy  = txReady;
        busy = txBusy;
        return;
      end
      @(negedge clk);
      lat++;
    end
  endtask

  // Complete transfer: stimulus, inhibit/RTS checks, frame vs model, done/err
  task automatic runTransfer(input vec_t v);
    logic [10:0] bits;
    logic [10:0] expFrame;
    bit          seen;
    logic        err, rdy, busy;
    int          lat;
    bit          sawDrive;
    expFrame = modelFrame(v.data);
    applyStimulus(v.data);
    checkInhibit();
    deviceFrame(v.ack, v.glitch, v.poke, 0, 0, bits);
    checkOutput("frame_bits", {21'd0, bits}, {21'd0, expFrame});
    checkOutput("parity_bit", {31'd0, bits[9]}, {31'd0, v.expParity});
    waitDone(seen, err, rdy, busy, lat);
    checkOutput("done_seen", {31'd0, seen}, 32'd1);
    if (seen) begin
      checkOutput("err_with_done", {31'd0, err}, {31'd0, v.expErr});
      checkOutput("ready_low_at_done", {31'd0, rdy}, 32'd0);
      checkOutput("busy_at_done", {31'd0, busy}, 32'd1);
      @(negedge clk);
      checkOutput("ready_after_done", {31'd0, txReady}, 32'd1);
      checkOutput("lines_released", {30'd0, clkDrv, dataDrv}, 32'd0);
    end
    if (v.poke) begin
      sawDrive = 1'b0;
      repeat (30) begin
        @(negedge clk);
        if (clkDrv || txBusy) sawDrive = 1'b1;
      end
      checkOutput("poke_ignored", {31'd0, sawDrive}, 32'd0);
    end
    repeat (5) @(negedge clk);
  endtask

  initial begin
    vec_t        r;
    logic [10:0] f;
    logic [10:0] bits;
    bit          seen;
    logic        err, rdy, busy;
    int          lat;
    bit          doneDuringAbort;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("reset_ready", {31'd0, txReady}, 32'd0);
    checkOutput("reset_busy", {31'd0, txBusy}, 32'd0);
    checkOutput("reset_done_err", {30'd0, txDone, txErr}, 32'd0);
    checkOutput("reset_drives", {30'd0, clkDrv, dataDrv}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("ready_after_reset", {31'd0, txReady}, 32'd1);

    // Directed vectors: data, ack, glitch, poke, expected parity, expected error
    vecs[0] = '{8'hED, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{8'hF4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 7; i++) begin
      runTransfer(vecs[i]);
    end

    // Randomised bytes and ACK behaviour against the frame model
    for (int i = 0; i < 4; i++) begin
      r.data      = 8'($urandom_range(0, 255));
      r.ack       = 1'($urandom_range(0, 1));
      r.glitch    = 1'b0;
      r.poke      = 1'b0;
      f           = modelFrame(r.data);
      r.expParity = f[9];
      r.expErr    = ~r.ack;
      runTransfer(r);
    end

    // Reset in the middle of data bit 4: lines drop at once, no done pulse
    applyStimulus(8'h00);
    checkInhibit();
    deviceFrame(1'b1, 1'b0, 1'b0, 4, 0, bits);
    doneDuringAbort = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (txDone) doneDuringAbort = 1'b1;
    end
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (txDone || clkDrv || dataDrv) doneDuringAbort = 1'b1;
    end
    checkOutput("no_done_after_abort", {31'd0, doneDuringAbort}, 32'd0);
    checkOutput("ready_after_abort", {31'd0, txReady}, 32'd1);

`ifdef PS2_TX_TIMEOUT_EN
    // Device stalls after bit 3: watchdog ends the transfer with an error
    applyStimulus(8'h55);
    checkInhibit();
    deviceFrame(1'b0, 1'b0, 1'b0, 0, 3, bits);
    waitDone(seen, err, rdy, busy, lat);
    checkOutput("timeout_done_seen", {31'd0, seen}, 32'd1);
    checkOutput("timeout_latency_in_window",
                {31'd0, (lat + HALF >= TO) && (lat + HALF <= TO + 15)}, 32'd1);
    checkOutput("timeout_err", {31'd0, err}, 32'd1);
    checkOutput("timeout_drives_released", {30'd0, clkDrv, dataDrv}, 32'd0);
    @(negedge clk);
    checkOutput("timeout_ready_after", {31'd0, txReady}, 32'd1);
`endif

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
